// File: rtl/fdivider.sv
// Single-precision IEEE-754 divider z = a / b using restoring division (one quotient bit per cycle).
// Latency: 3 cycles for special operands, 33 cycles otherwise (start-accept edge to valid edge).
// Backpressure: none; start is ignored while busy, and a new start is accepted in the valid cycle.
// Ports: clk, rst (async active-high), start/a/b request, busy, z (held until next result), valid pulse.
// Build option: define FDIV_FTZ_EN to flush denormal inputs and results to signed zero.
module fdivider #(
  parameter int QBITS = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] z,
  output logic        valid
);

  typedef enum logic [2:0] {
    IDLE, UNPACK, SPECIAL, NORM, DIVIDE, POSTNORM, ROUND, PACK
  } state_t;

  localparam logic [4:0] LAST_STEP = 5'(QBITS - 1);
  localparam logic [31:0] QNAN = 32'hFFC0_0000;

  state_t r_state, w_next;

  logic [31:0]       r_a, r_b, r_z, r_zspec;
  logic              r_s, r_special, r_valid;
  logic signed [9:0] r_ea, r_eb, r_ze;
  logic [23:0]       r_ma, r_mb, r_m;
  logic [24:0]       r_rem;
  logic [QBITS-1:0]  r_q;
  logic [4:0]        r_cnt;
  logic              r_g, r_r, r_st;

  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Operand classification straight from the latched raw words.
  logic w_sign, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_special;
  logic [31:0] w_spec_z;
  assign w_sign  = r_a[31] ^ r_b[31];
  assign w_a_nan = (&r_a[30:23]) & (|r_a[22:0]);
  assign w_b_nan = (&r_b[30:23]) & (|r_b[22:0]);
  assign w_a_inf = (&r_a[30:23]) & ~(|r_a[22:0]);
  assign w_b_inf = (&r_b[30:23]) & ~(|r_b[22:0]);
`ifdef FDIV_FTZ_EN
  assign w_a_zero = ~(|r_a[30:23]);
  assign w_b_zero = ~(|r_b[30:23]);
`else
  assign w_a_zero = ~(|r_a[30:0]);
  assign w_b_zero = ~(|r_b[30:0]);
`endif
  // Every special rule involves at least one NaN, inf or zero operand.
  assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

  always_comb begin
    w_spec_z = QNAN;
    if (w_a_nan | w_b_nan)                                  w_spec_z = QNAN;
    else if ((w_a_inf & w_b_inf) | (w_a_zero & w_b_zero))   w_spec_z = QNAN;
    else if (w_a_inf)                                       w_spec_z = {w_sign, 8'hFF, 23'h0};
    else if (w_b_inf)                                       w_spec_z = {w_sign, 31'h0};
    else if (w_b_zero)                                      w_spec_z = {w_sign, 8'hFF, 23'h0};
    else if (w_a_zero)                                      w_spec_z = {w_sign, 31'h0};
  end

  // Leading-zero normalisation of denormal mantissas.
  logic [4:0]  w_lza, w_lzb;
  logic [23:0] w_ma_n, w_mb_n;
  assign w_lza  = lzc24(r_ma);
  assign w_lzb  = lzc24(r_mb);
  assign w_ma_n = r_ma << w_lza;
  assign w_mb_n = r_mb << w_lzb;

  // One restoring step; the kept remainder is always below the divisor so the
  // shift never loses a set bit.
  logic        w_qbit;
  logic [24:0] w_sub, w_rem_keep;
  assign w_qbit     = (r_rem >= {1'b0, r_mb});
  assign w_sub      = r_rem - {1'b0, r_mb};
  assign w_rem_keep = w_qbit ? w_sub : r_rem;

  // Post-normalisation plus single-cycle denormalising shift of {m,g,r}.
  logic signed [9:0] w_ze1, w_uf_amt;
  logic [25:0]       w_ext, w_ext_sh, w_mask;
  logic              w_st0, w_uf, w_lost;
  logic [4:0]        w_sh;
  assign w_ze1    = r_q[QBITS-1] ? r_ze : r_ze - 10'sd1;
  assign w_ext    = r_q[QBITS-1] ? r_q[QBITS-1:1] : r_q[QBITS-2:0];
  assign w_st0    = (r_q[QBITS-1] & r_q[0]) | (|r_rem);
  assign w_uf     = (w_ze1 < -10'sd126);
  assign w_uf_amt = -10'sd126 - w_ze1;
  assign w_sh     = !w_uf ? 5'd0 : ((w_uf_amt > 10'sd26) ? 5'd26 : w_uf_amt[4:0]);
  assign w_ext_sh = w_ext >> w_sh;
  assign w_mask   = ~(26'h3FF_FFFF << w_sh);
  assign w_lost   = |(w_ext & w_mask);

  // Round to nearest even.
  logic        w_inc;
  logic [24:0] w_msum;
  assign w_inc  = r_g & (r_r | r_st | r_m[0]);
  assign w_msum = {1'b0, r_m} + {24'h0, w_inc};

  // Pack; hidden bit 0 can only occur at ze = -126 after the underflow shift.
  logic [7:0]  w_exp_f;
  logic [31:0] w_pack;
  assign w_exp_f = r_ze[7:0] + 8'd127;
  always_comb begin
    w_pack = {r_s, w_exp_f, r_m[22:0]};
    if (r_ze > 10'sd127) begin
      w_pack = {r_s, 8'hFF, 23'h0};
    end else if (!r_m[23]) begin
`ifdef FDIV_FTZ_EN
      w_pack = {r_s, 31'h0};
`else
      w_pack = {r_s, 8'h00, r_m[22:0]};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start) w_next = UNPACK;
      UNPACK:   w_next = SPECIAL;
      SPECIAL:  w_next = w_special ? PACK : NORM;
      NORM:     w_next = DIVIDE;
      DIVIDE:   if (r_cnt == LAST_STEP) w_next = POSTNORM;
      POSTNORM: w_next = ROUND;
      ROUND:    w_next = PACK;
      PACK:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_z <= '0; r_zspec <= '0;
      r_s <= 1'b0; r_special <= 1'b0; r_valid <= 1'b0;
      r_ea <= '0; r_eb <= '0; r_ze <= '0;
      r_ma <= '0; r_mb <= '0; r_m <= '0;
      r_rem <= '0; r_q <= '0; r_cnt <= '0;
      r_g <= 1'b0; r_r <= 1'b0; r_st <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_a       <= a;
          r_b       <= b;
          r_special <= 1'b0;
        end
        UNPACK: begin
          r_s  <= r_a[31] ^ r_b[31];
          r_ea <= (r_a[30:23] == 8'h00) ? -10'sd126 : $signed({2'b00, r_a[30:23]}) - 10'sd127;
          r_eb <= (r_b[30:23] == 8'h00) ? -10'sd126 : $signed({2'b00, r_b[30:23]}) - 10'sd127;
          r_ma <= {(r_a[30:23] != 8'h00), r_a[22:0]};
          r_mb <= {(r_b[30:23] != 8'h00), r_b[22:0]};
        end
        SPECIAL: begin
          r_special <= w_special;
          r_zspec   <= w_spec_z;
        end
        NORM: begin
          r_rem <= {1'b0, w_ma_n};
          r_mb  <= w_mb_n;
          r_ze  <= (r_ea - $signed({5'b0, w_lza})) - (r_eb - $signed({5'b0, w_lzb}));
          r_q   <= '0;
          r_cnt <= '0;
        end
        DIVIDE: begin
          r_q   <= {r_q[QBITS-2:0], w_qbit};
          r_rem <= w_rem_keep << 1;
          r_cnt <= r_cnt + 5'd1;
        end
        POSTNORM: begin
          r_m  <= w_ext_sh[25:2];
          r_g  <= w_ext_sh[1];
          r_r  <= w_ext_sh[0];
          r_st <= w_st0 | w_lost;
          r_ze <= w_uf ? -10'sd126 : w_ze1;
        end
        ROUND: begin
          if (w_msum[24]) begin
            r_m  <= 24'h80_0000;
            r_ze <= r_ze + 10'sd1;
          end else begin
            r_m <= w_msum[23:0];
          end
        end
        PACK: begin
          r_z     <= r_special ? r_zspec : w_pack;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != IDLE);
  assign z     = r_z;
  assign valid = r_valid;

endmodule

// File: doc/fdivider.md
Name: fdivider

Overview:
- Single-precision IEEE-754 floating-point divider (z = a / b). It is the inverse-operation companion to the team's fmultiplier and shares its unpack, special-case, normalise, round and pack conventions.
- Sequential: one quotient bit per cycle, restoring division.
- Start/valid handshake. Datapath blocks use it wherever an FP divide is needed.

Parameters:
- QBITS, 27, number of quotient bits generated: 24 mantissa + guard + round + 1 extra. Only the default is required to be supported.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  32  dividend (IEEE-754 single)
- b  input  32  divisor (IEEE-754 single)
- busy  output  1  high from the cycle after start is accepted until valid
- z  output  32  quotient; holds its value until the next result
- valid  output  1  one-cycle pulse; z is valid in that cycle

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; z=0, valid=0, busy=0; internal registers cleared.
  - Reset mid-operation aborts the divide; no valid is produced.
- Accepting a request:
  - At the edge where start=1 and state=IDLE, a and b are latched and busy rises.
  - start while busy=1 is ignored. Inputs may change freely after acceptance.
- FSM, one cycle per state unless stated:
  - IDLE -> UNPACK -> SPECIAL -> (PACK | NORM) -> DIVIDE (QBITS cycles) -> POSTNORM -> ROUND -> PACK -> IDLE.
- UNPACK:
  - Split sign, 8-bit exponent, 23-bit fraction.
  - Unbiased exponents are 10-bit signed.
  - Denormal: exponent forced to -126, hidden bit 0. Normal: hidden bit 1.
- SPECIAL, in priority order:
  1. Either operand NaN -> z=0xFFC00000.
  2. inf/inf or 0/0 -> 0xFFC00000.
  3. inf/x -> signed inf.
  4. x/inf -> signed zero.
  5. x/0 -> signed inf.
  6. 0/x -> signed zero.
  - Sign of every non-NaN result is sa^sb.
  - Special cases go straight to PACK.
- NORM: single-cycle leading-zero shift of denormal mantissas to bit 23; exponent decremented by the shift count.
- Exponent and division setup: ze = ea - eb. Restoring division of a_m by b_m (25-bit remainder) produces q[26:0], with q[26] weighted 2^0.
- POSTNORM:
  - If q[26]=1: mantissa=q[26:3], guard=q[2], round=q[1], sticky=q[0]|(rem!=0).
  - Else: mantissa=q[25:2], guard=q[1], round=q[0], sticky=(rem!=0), ze-=1.
  - If ze < -126: right-shift the mantissa by min(-126-ze, 26) in one cycle, with shifted-out bits ORed into sticky; ze=-126.
- ROUND: round-to-nearest-even; increment when guard & (round|sticky|m[0]).
  - Mantissa carry-out (0xFFFFFF+1) -> mantissa 0x800000, ze+=1.
- PACK:
  - ze > 127 -> signed inf.
  - ze = -126 with hidden bit 0 -> exponent field 0 (denormal or zero).
  - Otherwise exponent field = ze+127.
  - Rounding a denormal up to hidden bit 1 yields exponent field 1.
  - Pulse valid and drop busy in the same edge.
- Latency, counted from the start-accepting edge to the edge that raises valid:
  - Special cases: 3 cycles.
  - All other operands: 33 cycles, including denormal inputs and outputs.
- Back-to-back: a new start is accepted in the cycle valid is high (state is IDLE then).

Optional Feature:
- FDIV_FTZ_EN defined:
  - Denormal inputs are treated as signed zero in SPECIAL, so they follow the zero rules.
  - Results that would be denormal are flushed to signed zero in PACK.
  - Latency is unchanged.
- FDIV_FTZ_EN undefined: full gradual-underflow behaviour as specified in Behaviour.

Test Plan:
- a=0x40C00000, b=0x40000000, start 1 cycle -> z=0x40400000 with valid exactly 33 cycles later; same test with a=0xC0C00000 -> z=0xC0400000.
- a=0x3F800000, b=0x40400000 (1/3) -> z=0x3EAAAAAB (round-up path); a=0x3F800000, b=0x3F800000 -> 0x3F800000.
- Specials, each valid at 3 cycles: 0x3F800000/0x00000000 -> 0x7F800000; 0x00000000/0x00000000 -> 0xFFC00000; 0x7F800000/0x7F800000 -> 0xFFC00000; 0x80000000/0x40000000 -> 0x80000000; 0x7FC00000/0x3F800000 -> 0xFFC00000.
- Overflow/underflow: 0x7F000000/0x3E800000 -> 0x7F800000; 0x00800000/0x40000000 -> 0x00400000 (FDIV_FTZ_EN -> 0x00000000); 0x00000001/0x3F800000 -> 0x00000001.
- Handshake: pulse start again at cycle 10 of a divide with different operands -> ignored, first result unchanged, busy stays 1; start during the valid cycle -> accepted, second result 33 cycles later.
- Assert rst at cycle 15 of a divide -> z=0, busy=0, valid=0 immediately; no valid pulse afterwards; next start after release completes normally.
